idct_transpose8: RTL

IDCT_TRANSPOSE8 -- requirements
Module: idct_transpose8

---
 rtl/idct_pkg.sv | 15 +
 rtl/idct_tp_bank.sv | 32 +++
 rtl/idct_transpose8.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/idct_pkg.sv
// Shared definitions for the 8x8 IDCT pipeline: sample width, transform size
// and the ping-pong bank state encoding.
package idct_pkg;

    localparam int WIDTH = 25;
    localparam int N     = 8;

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILLING,
        BANK_FULL,
        BANK_DRAINING
    } bank_state_e;

endpackage

// File: rtl/idct_tp_bank.sv
// One 8x8 transpose bank: whole-row write port, whole-column read port.
// Contents are never cleared; the owning controller tracks validity.
module idct_tp_bank #(
    parameter int WIDTH = idct_pkg::WIDTH,
    parameter int N     = idct_pkg::N
) (
    input  logic                        clk,
    input  logic                        wr_en_i,
    input  logic [2:0]                  wr_row_i,
    input  logic [N-1:0][WIDTH-1:0]     wr_data_i,
    input  logic [2:0]                  rd_col_i,
    output logic [N-1:0][WIDTH-1:0]     rd_data_o
);

    logic [WIDTH-1:0] mem_q [N][N];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            for (int unsigned c = 0; c < N; c++) begin
                mem_q[wr_row_i][c] <= wr_data_i[c];
            end
        end
    end

    always_comb begin
        rd_data_o = '0;
        for (int unsigned r = 0; r < N; r++) begin
            rd_data_o[r] = mem_q[r][rd_col_i];
        end
    end

endmodule

// File: rtl/idct_transpose8.sv
// Row-to-column transpose buffer between the row and column IDCT passes,
// built from two ping-pong 8x8 banks with per-bank fill/drain state.
module idct_transpose8 #(
    parameter int WIDTH = idct_pkg::WIDTH,
    parameter int N     = idct_pkg::N
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_data_1,
    input  logic signed [WIDTH-1:0] in_data_2,
    input  logic signed [WIDTH-1:0] in_data_3,
    input  logic signed [WIDTH-1:0] in_data_4,
    input  logic signed [WIDTH-1:0] in_data_5,
    input  logic signed [WIDTH-1:0] in_data_6,
    input  logic signed [WIDTH-1:0] in_data_7,
    input  logic signed [WIDTH-1:0] in_data_8,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_data_1,
    output logic signed [WIDTH-1:0] out_data_2,
    output logic signed [WIDTH-1:0] out_data_3,
    output logic signed [WIDTH-1:0] out_data_4,
    output logic signed [WIDTH-1:0] out_data_5,
    output logic signed [WIDTH-1:0] out_data_6,
    output logic signed [WIDTH-1:0] out_data_7,
    output logic signed [WIDTH-1:0] out_data_8,
    output logic [2:0]              out_col,
    output logic                    out_last
);
    import idct_pkg::*;

    bank_state_e              state_q [2];
    bank_state_e              state_d [2];
    logic                     wr_bank_q, wr_bank_d;
    logic                     rd_bank_q, rd_bank_d;
    logic [2:0]               wr_row_q, wr_row_d;
    logic [2:0]               rd_col_q, rd_col_d;
    logic                     in_ready_q, in_ready_d;
    logic                     in_fire, out_fire;
    logic [1:0]               bank_wr, bank_rd;
    logic [N-1:0][WIDTH-1:0]  wr_data;
    logic [N-1:0][WIDTH-1:0]  rd_data [2];
    logic [N-1:0][WIDTH-1:0]  col_data;

    assign wr_data = {in_data_8, in_data_7, in_data_6, in_data_5,
                      in_data_4, in_data_3, in_data_2, in_data_1};

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q[rd_bank_q] == BANK_FULL) ||
                       (state_q[rd_bank_q] == BANK_DRAINING);
    assign out_col   = rd_col_q;
    assign out_last  = out_valid && (rd_col_q == 3'd7);

    always_comb begin
        in_fire   = in_valid && in_ready_q;
        out_fire  = out_valid && out_ready;
        wr_row_d  = wr_row_q;
        wr_bank_d = wr_bank_q;
        rd_col_d  = rd_col_q;
        rd_bank_d = rd_bank_q;
        bank_wr   = '0;
        bank_rd   = '0;

        if (in_fire) begin
            wr_row_d = wr_row_q + 3'd1;
            if (wr_row_q == 3'd7) wr_bank_d = ~wr_bank_q;
        end
        if (out_fire) begin
            rd_col_d = rd_col_q + 3'd1;
            if (rd_col_q == 3'd7) rd_bank_d = ~rd_bank_q;
        end

        for (int unsigned b = 0; b < 2; b++) begin
            bank_wr[b] = in_fire  && (wr_bank_q == 1'(b));
            bank_rd[b] = out_fire && (rd_bank_q == 1'(b));
            state_d[b] = state_q[b];
            case (state_q[b])
                BANK_EMPTY:    if (bank_wr[b]) state_d[b] = BANK_FILLING;
                BANK_FILLING:  if (bank_wr[b] && wr_row_q == 3'd7) state_d[b] = BANK_FULL;
                BANK_FULL:     if (bank_rd[b]) state_d[b] = BANK_DRAINING;
                BANK_DRAINING: if (bank_rd[b] && rd_col_q == 3'd7) state_d[b] = BANK_EMPTY;
                default:       state_d[b] = BANK_EMPTY;
            endcase
        end

        // Ready looks one cycle ahead so a bank freed this cycle is writable next cycle.
        in_ready_d = (state_d[wr_bank_d] == BANK_EMPTY) ||
                     (state_d[wr_bank_d] == BANK_FILLING);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q[0] <= BANK_EMPTY;
            state_q[1] <= BANK_EMPTY;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            wr_row_q   <= '0;
            rd_col_q   <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q[0] <= state_d[0];
            state_q[1] <= state_d[1];
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            wr_row_q   <= wr_row_d;
            rd_col_q   <= rd_col_d;
            in_ready_q <= in_ready_d;
        end
    end

    idct_tp_bank #(.WIDTH(WIDTH), .N(N)) u_bank0 (
        .clk       (clk),
        .wr_en_i   (bank_wr[0]),
        .wr_row_i  (wr_row_q),
        .wr_data_i (wr_data),
        .rd_col_i  (rd_col_q),
        .rd_data_o (rd_data[0])
    );

    idct_tp_bank #(.WIDTH(WIDTH), .N(N)) u_bank1 (
        .clk       (clk),
        .wr_en_i   (bank_wr[1]),
        .wr_row_i  (wr_row_q),
        .wr_data_i (wr_data),
        .rd_col_i  (rd_col_q),
        .rd_data_o (rd_data[1])
    );

    assign col_data   = out_valid ? rd_data[rd_bank_q] : '0;
    assign out_data_1 = col_data[0];
    assign out_data_2 = col_data[1];
    assign out_data_3 = col_data[2];
    assign out_data_4 = col_data[3];
    assign out_data_5 = col_data[4];
    assign out_data_6 = col_data[5];
    assign out_data_7 = col_data[6];
    assign out_data_8 = col_data[7];

endmodule
